// File: rtl/alu_pkg.sv
// Shared ALU select codes, arbiter FSM encoding and width defaults for the ALU sharing logic.
// The helper sel_legal backs the optional ALU_SEL_CHECK_EN select check.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic sel_legal(input logic [3:0] sel);
    logic ok;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Scan from ptr upward; the first hit wins and later hits are masked by any.
  always_comb begin
    int sum;
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = 0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(ptr) + k;
      j   = (sum >= N_REQ) ? (sum - N_REQ) : sum;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_SEL_CHECK_EN flags illegal selects via resp_err; otherwise resp_err is 0.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op1,
  input  logic [N_REQ*DATA_W-1:0] req_op2,
  input  logic [N_REQ*SEL_W-1:0]  req_sel,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic [DATA_W-1:0]       alu_op1,
  output logic [DATA_W-1:0]       alu_op2,
  output logic [SEL_W-1:0]        alu_sel,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [IDX_W-1:0] ptr_after;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign ptr_after = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : (grant_idx + IDX_W'(1));

  // Next-state and handshake strobes; req_ready only looks at req_valid, never resp_ready.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_any) state_nxt = EXEC;
        else         state_nxt = IDLE;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp_valid[grant_idx] = 1'b1;
        if (resp_ready[grant_idx]) state_nxt = IDLE;
        else                       state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      alu_sel   <= SEL_W'(ALU_ADD);
      resp_data <= '0;
      resp_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_any) begin
            alu_op1   <= req_op1[int'(arb_idx)*DATA_W +: DATA_W];
            alu_op2   <= req_op2[int'(arb_idx)*DATA_W +: DATA_W];
            alu_sel   <= req_sel[int'(arb_idx)*SEL_W +: SEL_W];
            grant_idx <= arb_idx;
          end
        end
        EXEC: begin
`ifdef ALU_SEL_CHECK_EN
          if (sel_legal(4'(alu_sel))) begin
            resp_data <= alu_result;
            resp_zero <= alu_zero;
          end else begin
            resp_data <= '0;
            resp_zero <= 1'b1;
          end
`else
          resp_data <= alu_result;
          resp_zero <= alu_zero;
`endif
        end
        RESP: begin
          if (resp_ready[grant_idx]) rr_ptr <= ptr_after;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEL_CHECK_EN
  logic err_q;

  // Illegal-select flag, captured alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (state == EXEC)  err_q <= !sel_legal(4'(alu_sel));
    else                     err_q <= err_q;
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_op1;
  logic [N*DW-1:0] req_op2;
  logic [N*SW-1:0] req_sel;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_data;
  logic            resp_zero;
  logic            resp_err;
  logic [DW-1:0]   alu_op1;
  logic [DW-1:0]   alu_op2;
  logic [SW-1:0]   alu_sel;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arbiter #(.N_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown selects return a recognisable junk pattern.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0011: alu_result = alu_op1 * alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s);
    req_op1[idx*DW +: DW] = a;
    req_op2[idx*DW +: DW] = b;
    req_sel[idx*SW +: SW] = s;
    req_valid[idx]        = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 2'b11;
    req_op1 = '0; req_op2 = '0; req_sel = '0;
    repeat (2) @(negedge clk);
    if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    n_cmp++;
    if (resp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    n_cmp++;
    if ({alu_op1, alu_op2, alu_sel} !== {32'd0, 32'd0, 4'b0010}) begin
      n_bad++; $display("FAIL reset_alu_regs got %h %h %b want 0 0 0010", alu_op1, alu_op2, alu_sel);
    end
    n_cmp++;
    if ({resp_data, resp_zero, resp_err} !== {32'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_resp got %h %b %b want 0 0 0", resp_data, resp_zero, resp_err);
    end
    n_cmp++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd7, 4'b0010);
    @(negedge clk);
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b want 01", req_ready); end
    n_cmp++;
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    if (resp_valid !== 2'b00 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin
      n_bad++; $display("FAIL single_exec got rv=%b op1=%0d op2=%0d want 00 5 7", resp_valid, alu_op1, alu_op2);
    end
    n_cmp++;
    @(negedge clk);
    if (resp_valid !== 2'b01 || resp_data !== 32'd12 || resp_zero !== 1'b0) begin
      n_bad++; $display("FAIL single_resp got rv=%b d=%0d z=%b want 01 12 0", resp_valid, resp_data, resp_zero);
    end
    n_cmp++;
    @(negedge clk);
    if (resp_valid !== 2'b00) begin n_bad++; $display("FAIL single_done got %b want 00", resp_valid); end
    n_cmp++;
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    set_req(1, 32'd9, 32'd9, 4'b0110);
    @(negedge clk);
    if (req_ready !== 2'b10) begin n_bad++; $display("FAIL zero_ready got %b want 10", req_ready); end
    n_cmp++;
    @(posedge clk); #1; req_valid = '0;
    repeat (2) @(negedge clk);
    if (resp_valid !== 2'b10 || resp_data !== 32'd0 || resp_zero !== 1'b1) begin
      n_bad++; $display("FAIL zero_resp got rv=%b d=%0d z=%b want 10 0 1", resp_valid, resp_data, resp_zero);
    end
    n_cmp++;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    set_req(0, 32'd3, 32'd4, 4'b0111);
    set_req(1, 32'd3, 32'd4, 4'b0111);
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      if (req_ready !== exp_g) begin n_bad++; $display("FAIL contend_grant%0d got %b want %b", t, req_ready, exp_g); end
      n_cmp++;
      repeat (2) @(negedge clk);
      if (resp_valid !== exp_g || resp_data !== 32'd1 || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL contend_resp%0d got rv=%b d=%0d rr=%b want %b 1 00", t, resp_valid, resp_data, req_ready, exp_g);
      end
      n_cmp++;
    end
    @(posedge clk); #1; req_valid = '0;
  endtask

  task automatic test_backpressure();
    resp_ready = 2'b10;
    set_req(0, 32'h000000F0, 32'h0000000F, 4'b0001);
    @(negedge clk);
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_ready got %b want 01", req_ready); end
    n_cmp++;
    @(posedge clk); #1; req_valid[0] = 1'b0;
    set_req(1, 32'd1, 32'd1, 4'b0010);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid !== 2'b01 || resp_data !== 32'hFF || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL bp_hold%0d got rv=%b d=%h rr=%b want 01 ff 00", c, resp_valid, resp_data, req_ready);
      end
      n_cmp++;
    end
    #1 resp_ready = 2'b11;
    @(negedge clk);
    if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
      n_bad++; $display("FAIL bp_release got rv=%b rr=%b want 00 10", resp_valid, req_ready);
    end
    n_cmp++;
    #1 req_valid = '0;
    repeat (2) @(negedge clk);
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || alu_op1 !== 32'hF0 || alu_sel !== 4'b0001) begin
      n_bad++; $display("FAIL bp_drop got rr=%b rv=%b op1=%h sel=%b want 00 00 f0 0001", req_ready, resp_valid, alu_op1, alu_sel);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    set_req(0, 32'd6, 32'd7, 4'b0011);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (alu_op1 !== 32'd0 || alu_sel !== 4'b0010 || resp_valid !== 2'b00 || resp_data !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_vals got op1=%0d sel=%b rv=%b d=%0d want 0 0010 00 0", alu_op1, alu_sel, resp_valid, resp_data);
    end
    n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) begin n_bad++; $display("FAIL rstmid_noresp%0d got %b want 00", c, resp_valid); end
      n_cmp++;
    end
    @(posedge clk); #1;
    set_req(0, 32'd6, 32'd7, 4'b0011);
    @(posedge clk); #1; req_valid = '0;
    repeat (2) @(negedge clk);
    if (resp_valid !== 2'b01 || resp_data !== 32'd42) begin
      n_bad++; $display("FAIL rstmid_new got rv=%b d=%0d want 01 42", resp_valid, resp_data);
    end
    n_cmp++;
    @(posedge clk); #1;
  endtask

  task automatic test_sel_check();
    logic [31:0] exp_d;
    logic        exp_z;
    logic        exp_e;
`ifdef ALU_SEL_CHECK_EN
    exp_d = 32'd0; exp_z = 1'b1; exp_e = 1'b1;
`else
    exp_d = 32'hDEADBEEF; exp_z = 1'b0; exp_e = 1'b0;
`endif
    set_req(1, 32'd3, 32'd4, 4'b1111);
    @(posedge clk); #1; req_valid = '0;
    repeat (2) @(negedge clk);
    if (resp_valid !== 2'b10 || resp_data !== exp_d || resp_zero !== exp_z || resp_err !== exp_e) begin
      n_bad++; $display("FAIL selchk got rv=%b d=%h z=%b e=%b want 10 %h %b %b", resp_valid, resp_data, resp_zero, resp_err, exp_d, exp_z, exp_e);
    end
    n_cmp++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_sel_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
